segments_scan_decoder: RTL

// Receive-side counterpart of the 7-segment driver: snoops a multiplexed display (segment bus + digit select)
// and recovers the BCD value shown on each digit. Sits behind display pins/board loopback for self-test
// and readback. Captures a digit only after its pattern is stable, flags undecodable patterns, pulses per frame.

---
 rtl/segments_scan_decoder_if.sv | 33 +++
 rtl/segments_scan_decoder.sv | 118 +++++++++++
 2 files changed

// File: rtl/segments_scan_decoder_if.sv
// Bus bundle between a multiplexed 7-segment display and the scan decoder that snoops it.
// The master drives the display side; the slave (decoder) returns the recovered digits.
interface segments_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [7:0]          segment_value_bus;
  logic [DIGITS-1:0]   digit_select_bus;
  logic [4*DIGITS-1:0] digit_value_bus;
  logic [DIGITS-1:0]   dp_bus;
  logic [DIGITS-1:0]   digit_valid_bus;
  logic                invalid_pattern;
  logic                frame_done;

  modport master (
    output segment_value_bus,
    output digit_select_bus,
    input  digit_value_bus,
    input  dp_bus,
    input  digit_valid_bus,
    input  invalid_pattern,
    input  frame_done
  );

  modport slave (
    input  segment_value_bus,
    input  digit_select_bus,
    output digit_value_bus,
    output dp_bus,
    output digit_valid_bus,
    output invalid_pattern,
    output frame_done
  );
endinterface

// File: rtl/segments_scan_decoder.sv
// Snoops a multiplexed 7-segment bus and recovers the BCD value of each digit once its
// pattern has been stable long enough; flags undecodable patterns and pulses per full frame.
module segments_scan_decoder #(
  parameter logic CONTROL_TYPE_V = 1'b0,
  parameter int   DIGITS         = 4,
  parameter int   STABLE_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  segments_scan_decoder_if.slave  dec_if
);
  localparam int SW = DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {TRACK, HELD} state_t;

  state_t              state;
  logic [SW-1:0]       sample_q;
  logic [SW-1:0]       prev_q;
  logic [CW-1:0]       cnt_q;
  logic [DIGITS-1:0]   mask_q;
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   valid_q;
  logic                invalid_q;
  logic                frame_q;

  logic [DIGITS-1:0]   sel;
  logic [6:0]          seg_on;
  logic                dp_on;
  logic                sel_onehot;
  logic                changed;
  logic                mask_full;
  logic [CW-1:0]       cnt_next;
  logic                capture;
  logic [3:0]          decoded;

  // Capture fires on the edge where the stability counter reaches its limit while still tracking.
  always_comb begin
    sel        = sample_q[SW-1:8];
    seg_on     = sample_q[7:1];
    dp_on      = sample_q[0];
    sel_onehot = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
    changed    = (sample_q != prev_q);
    mask_full  = &mask_q;

    cnt_next = '0;
    if (!sel_onehot)
      cnt_next = '0;
    else if (changed)
      cnt_next = CW'(1);
    else if (cnt_q == CNT_MAX)
      cnt_next = cnt_q;
    else
      cnt_next = cnt_q + CW'(1);

    capture = (state == TRACK) && sel_onehot && (cnt_next == CNT_MAX);

    decoded = 4'hF;
    case (seg_on)
      7'b1111110: decoded = 4'd0;
      7'b0110000: decoded = 4'd1;
      7'b1101101: decoded = 4'd2;
      7'b1111001: decoded = 4'd3;
      7'b0110011: decoded = 4'd4;
      7'b1011011: decoded = 4'd5;
      7'b1011111: decoded = 4'd6;
      7'b1110000: decoded = 4'd7;
      7'b1111111: decoded = 4'd8;
      7'b1111011: decoded = 4'd9;
      default:    decoded = 4'hF;
    endcase
  end

  // A capture landing on the frame-clear edge re-sets its own mask bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TRACK;
      sample_q  <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      invalid_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      sample_q  <= {dec_if.digit_select_bus, dec_if.segment_value_bus ^ {8{CONTROL_TYPE_V}}};
      prev_q    <= sample_q;
      cnt_q     <= cnt_next;
      invalid_q <= capture && (decoded == 4'hF);
      frame_q   <= mask_full;
      mask_q    <= (mask_full ? '0 : mask_q) | (capture ? sel : '0);

      case (state)
        TRACK:   if (capture) state <= HELD;
        HELD:    if (changed) state <= TRACK;
        default: state <= TRACK;
      endcase

      for (int i = 0; i < DIGITS; i++) begin
        if (capture && sel[i]) begin
          value_q[4*i +: 4] <= decoded;
          dp_q[i]           <= dp_on;
          valid_q[i]        <= 1'b1;
        end
      end
    end
  end

  assign dec_if.digit_value_bus = value_q;
  assign dec_if.dp_bus          = dp_q;
  assign dec_if.digit_valid_bus = valid_q;
  assign dec_if.invalid_pattern = invalid_q;
  assign dec_if.frame_done      = frame_q;
endmodule
